// File: rtl/speck_dec_frontend.sv
// speck_dec_frontend: assembles key/ciphertext from a word stream, launches the SPECK decrypt core, captures its plaintext
module speck_dec_frontend #(
  parameter int KEY_SIZE       = 128,
  parameter int WORD_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sel,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  err_clr,
  output logic                  dec_start,
  output logic [KEY_SIZE-1:0]   dec_key,
  output logic [KEY_SIZE-1:0]   dec_ciphertext,
  input  logic                  dec_ready,
  input  logic [KEY_SIZE-1:0]   dec_plaintext,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [KEY_SIZE-1:0]   out_data,
  output logic                  busy,
  output logic                  key_valid,
  output logic                  err_overflow,
  output logic                  err_timeout
);
  localparam int NW = KEY_SIZE / WORD_WIDTH;
  localparam int CW = $clog2(NW);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {COLLECT, LAUNCH, WAIT_DONE, OUT} state_t;

  state_t              state_q, state_d;
  logic [KEY_SIZE-1:0] key_q, key_d, ct_q, ct_d, out_q, out_d;
  logic [CW-1:0]       key_cnt_q, key_cnt_d, ct_cnt_q, ct_cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                key_valid_q, key_valid_d, ct_full_q, ct_full_d;
  logic                ovf_q, ovf_d, tmo_err_q, tmo_err_d;
  logic                in_ready_q, in_ready_d, start_q, start_d;
  logic                out_valid_q, out_valid_d, busy_q, busy_d;
  logic                accept, ovf_set, tmo_set;

  assign accept = (state_q == COLLECT) && in_valid && in_ready_q;

  // next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    ct_d        = ct_q;
    out_d       = out_q;
    key_cnt_d   = key_cnt_q;
    ct_cnt_d    = ct_cnt_q;
    tmo_d       = tmo_q;
    key_valid_d = key_valid_q;
    ct_full_d   = ct_full_q;
    ovf_set     = 1'b0;
    tmo_set     = 1'b0;
    if (accept && in_sel) begin
      key_d       = {key_q[KEY_SIZE-WORD_WIDTH-1:0], in_data};
      key_cnt_d   = key_cnt_q + CW'(1);
      key_valid_d = (key_cnt_q == CW'(NW-1)) ? 1'b1 : (key_cnt_q == '0) ? 1'b0 : key_valid_q;
    end
    if (accept && !in_sel && ct_full_q)
      ovf_set = 1'b1;
    if (accept && !in_sel && !ct_full_q) begin
      ct_d      = {ct_q[KEY_SIZE-WORD_WIDTH-1:0], in_data};
      ct_cnt_d  = ct_cnt_q + CW'(1);
      ct_full_d = (ct_cnt_q == CW'(NW-1));
    end
    if (state_q == COLLECT && ct_full_d && key_valid_d)
      state_d = LAUNCH;
    if (state_q == LAUNCH)
      state_d = WAIT_DONE;
    if (state_q == WAIT_DONE) begin
      if (dec_ready) begin
        out_d     = dec_plaintext;
        ct_full_d = 1'b0;
        tmo_d     = '0;
        state_d   = OUT;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES-1)) begin
        tmo_set   = 1'b1;
        ct_full_d = 1'b0;
        tmo_d     = '0;
        state_d   = COLLECT;
      end else
        tmo_d = tmo_q + TW'(1);
    end
    if (state_q == OUT && out_ready)
      state_d = COLLECT;
    ovf_d       = (ovf_q & ~err_clr) | ovf_set;
    tmo_err_d   = (tmo_err_q & ~err_clr) | tmo_set;
    in_ready_d  = (state_d == COLLECT);
    start_d     = (state_d == LAUNCH);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != COLLECT);
  end

  // all state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      key_q       <= '0;
      ct_q        <= '0;
      out_q       <= '0;
      key_cnt_q   <= '0;
      ct_cnt_q    <= '0;
      tmo_q       <= '0;
      key_valid_q <= 1'b0;
      ct_full_q   <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_err_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      ct_q        <= ct_d;
      out_q       <= out_d;
      key_cnt_q   <= key_cnt_d;
      ct_cnt_q    <= ct_cnt_d;
      tmo_q       <= tmo_d;
      key_valid_q <= key_valid_d;
      ct_full_q   <= ct_full_d;
      ovf_q       <= ovf_d;
      tmo_err_q   <= tmo_err_d;
      in_ready_q  <= in_ready_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign dec_start      = start_q;
  assign dec_key        = key_q;
  assign dec_ciphertext = ct_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_q;
  assign busy           = busy_q;
  assign key_valid      = key_valid_q;
  assign err_overflow   = ovf_q;
  assign err_timeout    = tmo_err_q;
endmodule

// File: tb/tb_speck_dec_frontend.sv
// tb_speck_dec_frontend: scoreboard bench for the SPECK decrypt front end with a mock core
module tb_speck_dec_frontend;
  localparam logic [127:0] K0 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] C0 = 128'ha65d9851797832657860fedf5c570d18;
  localparam logic [127:0] P0 = 128'h6c617669757165207469206564616d20;
  localparam logic [127:0] K1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C2 = 128'hcafef00d12345678deadbeef55aa33cc;

  logic clk = 0, rst_n = 0, in_valid = 0, in_sel = 0, err_clr = 0, dec_ready = 0, out_ready = 0;
  logic [15:0]  in_data = '0;
  logic [127:0] dec_plaintext = '0;
  logic         in_ready, dec_start, out_valid, busy, key_valid, err_overflow, err_timeout;
  logic [127:0] dec_key, dec_ciphertext, out_data;
  logic         t_in_ready, t_dec_start, t_out_valid, t_busy, t_key_valid, t_err_overflow, t_err_timeout;
  logic [127:0] t_dec_key, t_dec_ciphertext, t_out_data;
  int checks = 0, fails = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  speck_dec_frontend dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_data(in_data), .err_clr(err_clr), .dec_start(dec_start), .dec_key(dec_key),
    .dec_ciphertext(dec_ciphertext), .dec_ready(dec_ready), .dec_plaintext(dec_plaintext),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .key_valid(key_valid), .err_overflow(err_overflow), .err_timeout(err_timeout));

  speck_dec_frontend #(.TIMEOUT_CYCLES(16)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready), .in_sel(in_sel),
    .in_data(in_data), .err_clr(err_clr), .dec_start(t_dec_start), .dec_key(t_dec_key),
    .dec_ciphertext(t_dec_ciphertext), .dec_ready(dec_ready), .dec_plaintext(dec_plaintext),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data), .busy(t_busy),
    .key_valid(t_key_valid), .err_overflow(t_err_overflow), .err_timeout(t_err_timeout));

  function automatic logic [127:0] pt_of(input logic [127:0] k, input logic [127:0] c);
    return (k == K0 && c == C0) ? P0 : k ^ {c[63:0], c[127:64]};
  endfunction

  task automatic do_reset();
    rst_n = 0; in_valid = 0; err_clr = 0; dec_ready = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic send_word(input logic sel, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_sel = sel; in_data = d;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin fails++; checks++; $display("FAIL send_word in_ready=%b required 1", in_ready); end
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic load_vec(input logic sel, input logic [127:0] v);
    for (int i = 0; i < 8; i++) send_word(sel, v[127-16*i -: 16]);
  endtask

  task automatic respond(input int d);
    repeat (d) @(negedge clk);
    dec_ready = 1; dec_plaintext = pt_of(dec_key, dec_ciphertext);
    @(negedge clk);
    dec_ready = 0; dec_plaintext = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++; if ({in_ready, dec_start, out_valid, busy, key_valid, err_overflow, err_timeout} !== 7'b0) begin fails++; $display("FAIL reset_flags got %b required 0", {in_ready, dec_start, out_valid, busy, key_valid, err_overflow, err_timeout}); end
    checks++; if ({dec_key, dec_ciphertext, out_data} !== '0) begin fails++; $display("FAIL reset_data got %h/%h/%h required 0", dec_key, dec_ciphertext, out_data); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [127:0] e;
    do_reset();
    load_vec(1, K0); load_vec(0, C0); exp_q.push_back(P0);
    @(negedge clk);
    checks++; if (dec_start !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL launch start=%b busy=%b required 1/1", dec_start, busy); end
    checks++; if (dec_key !== K0 || dec_ciphertext !== C0) begin fails++; $display("FAIL launch_vec key=%h ct=%h required %h/%h", dec_key, dec_ciphertext, K0, C0); end
    @(negedge clk);
    checks++; if (dec_start !== 1'b0) begin fails++; $display("FAIL start_pulse_width got %b required 0", dec_start); end
    repeat (48) @(negedge clk);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL wait busy=%b ov=%b ir=%b required 1/0/0", busy, out_valid, in_ready); end
    respond(0);
    e = exp_q.size() ? exp_q.pop_front() : 'x;
    checks++; if (out_valid !== 1'b1 || out_data !== e) begin fails++; $display("FAIL capture ov=%b data=%h required 1/%h", out_valid, out_data, e); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== e) begin fails++; $display("FAIL hold%0d ov=%b data=%h required 1/%h", i, out_valid, out_data, e); end
    end
    out_ready = 1; @(negedge clk); out_ready = 0;
    checks++; if ({out_valid, busy, key_valid, in_ready} !== 4'b0011) begin fails++; $display("FAIL handshake ov/busy/kv/ir=%b required 0011", {out_valid, busy, key_valid, in_ready}); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] e;
    int n;
    do_reset();
    for (int v = 0; v < 2; v++) begin
      if (v == 0) begin
        load_vec(0, C1); exp_q.push_back(pt_of(K1, C1));
        @(negedge clk);
        checks++; if (dec_start !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL ct_only start=%b busy=%b required 0/0", dec_start, busy); end
        for (int i = 0; i < 7; i++) send_word(1, K1[127-16*i -: 16]);
        @(negedge clk);
        checks++; if (dec_start !== 1'b0 || key_valid !== 1'b0) begin fails++; $display("FAIL key7 start=%b kv=%b required 0/0", dec_start, key_valid); end
        send_word(1, K1[15:0]);
      end else begin
        load_vec(0, C2); exp_q.push_back(pt_of(K1, C2));
      end
      @(negedge clk);
      checks++; if (dec_start !== 1'b1 || dec_key !== K1) begin fails++; $display("FAIL b2b_launch%0d start=%b key=%h required 1/%h", v, dec_start, dec_key, K1); end
      respond(3);
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      e = exp_q.size() ? exp_q.pop_front() : 'x;
      checks++; if (out_valid !== 1'b1 || out_data !== e) begin fails++; $display("FAIL b2b_out%0d ov=%b data=%h required 1/%h", v, out_valid, out_data, e); end
      out_ready = 1; @(negedge clk); out_ready = 0;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    load_vec(1, K0); load_vec(0, C0);
    @(negedge clk);
    checks++; if (t_dec_start !== 1'b1) begin fails++; $display("FAIL t_launch got %b required 1", t_dec_start); end
    repeat (16) @(negedge clk);
    checks++; if (t_err_timeout !== 1'b0 || t_busy !== 1'b1) begin fails++; $display("FAIL tmo_early err=%b busy=%b required 0/1", t_err_timeout, t_busy); end
    @(negedge clk);
    checks++; if ({t_err_timeout, t_in_ready, t_busy, t_key_valid} !== 4'b1101) begin fails++; $display("FAIL tmo err/ir/busy/kv=%b required 1101", {t_err_timeout, t_in_ready, t_busy, t_key_valid}); end
    err_clr = 1; @(negedge clk); err_clr = 0;
    checks++; if (t_err_timeout !== 1'b0) begin fails++; $display("FAIL tmo_clr got %b required 0", t_err_timeout); end
  endtask

  task automatic test_overflow();
    do_reset();
    load_vec(0, C0);
    send_word(0, 16'hdead);
    @(negedge clk);
    checks++; if (err_overflow !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL ovf err=%b busy=%b required 1/0", err_overflow, busy); end
    checks++; if (dec_ciphertext !== C0) begin fails++; $display("FAIL ovf_ct got %h required %h", dec_ciphertext, C0); end
    in_valid = 1; in_sel = 0; in_data = 16'hbeef; err_clr = 1;
    @(posedge clk); #1 in_valid = 0; err_clr = 0;
    @(negedge clk);
    checks++; if (err_overflow !== 1'b1) begin fails++; $display("FAIL ovf_set_wins got %b required 1", err_overflow); end
    err_clr = 1; @(negedge clk); err_clr = 0;
    checks++; if (err_overflow !== 1'b0) begin fails++; $display("FAIL ovf_clr got %b required 0", err_overflow); end
  endtask

  task automatic test_async_reset();
    logic seen = 0;
    do_reset();
    load_vec(1, K0); load_vec(0, C0);
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++; if ({in_ready, dec_start, out_valid, busy, key_valid, err_overflow, err_timeout} !== 7'b0 || {dec_key, dec_ciphertext, out_data} !== '0) begin fails++; $display("FAIL async_rst flags=%b key=%h ct=%h required 0", {in_ready, dec_start, out_valid, busy, key_valid, err_overflow, err_timeout}, dec_key, dec_ciphertext); end
    @(negedge clk); rst_n = 1;
    repeat (20) begin @(negedge clk); seen = seen | dec_start | busy; end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL post_rst_start got %b required 0", seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_overflow();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
